// File: rtl/vp_095_seq.sv
// vp_095_seq: bus-cycle sequencer for a pair of vp_095 bridge slices.
// It runs DATI, DATO(B) and DATIO(B) peripheral cycles for central window hits and returns RPLY.
module vp_095_seq #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic       PIN_CLK,
    input  logic       PIN_nRST,
    input  logic       PIN_nSYNCC,
    input  logic       PIN_nDINC,
    input  logic       PIN_nDOUTC,
    input  logic       PIN_nWTBTC,
    input  logic [1:0] PIN_nCMPC,
    input  logic       PIN_nRPLYP,
    output logic       PIN_nRPLYC,
    output logic       PIN_nSYNCP,
    output logic       PIN_nDINP,
    output logic       PIN_nDOUTP,
    output logic       PIN_nWTBTP,
    output logic       PIN_nDLA,
    output logic       PIN_nDLD,
    output logic       PIN_nCLD,
    output logic       PIN_nOEP,
    output logic       PIN_nOEC,
    output logic       PIN_BUSY,
    output logic       PIN_TOUT
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_SYNC,
        S_WAITDS,
        S_WDATA,
        S_WAITRP,
        S_RDLAT,
        S_RPLY,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_q, rd_d;
    logic          wtbt_q, wtbt_d;
    logic          skip_q, skip_d;
    logic          cont_q, cont_d;
    logic [6:0]    meta_q, meta_d;
    logic [6:0]    sync_q, sync_d;
    logic          nsyncc_prev_q, nsyncc_prev_d;

    logic       s_nsyncc, s_ndinc, s_ndoutc, s_nwtbtc, s_nrplyp;
    logic [1:0] s_ncmpc;
    logic       sync_fall;

    always_comb begin
        meta_d        = {PIN_nSYNCC, PIN_nDINC, PIN_nDOUTC, PIN_nWTBTC, PIN_nCMPC, PIN_nRPLYP};
        sync_d        = meta_q;
        nsyncc_prev_d = sync_q[6];
        s_nsyncc      = sync_q[6];
        s_ndinc       = sync_q[5];
        s_ndoutc      = sync_q[4];
        s_nwtbtc      = sync_q[3];
        s_ncmpc       = sync_q[2:1];
        s_nrplyp      = sync_q[0];
        sync_fall     = nsyncc_prev_q & ~s_nsyncc;
    end

    always_ff @(posedge PIN_CLK or negedge PIN_nRST) begin
        if (!PIN_nRST) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rd_q          <= 1'b0;
            wtbt_q        <= 1'b1;
            skip_q        <= 1'b0;
            cont_q        <= 1'b0;
            meta_q        <= '1;
            sync_q        <= '1;
            nsyncc_prev_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            wtbt_q        <= wtbt_d;
            skip_q        <= skip_d;
            cont_q        <= cont_d;
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            nsyncc_prev_q <= nsyncc_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rd_d    = rd_q;
        wtbt_d  = wtbt_q;
        skip_d  = skip_q;
        cont_d  = cont_q;
        if (s_nsyncc) begin
            skip_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (sync_fall && !skip_q) begin
                    if (s_ncmpc == 2'b00) begin
                        state_d = S_ADDR;
                    end else begin
                        skip_d = 1'b1;
                    end
                end
            end
            // One latch clock followed by T_SETUP clocks of address drive.
            S_ADDR: begin
                if (cnt_q == CW'(T_SETUP)) begin
                    state_d = S_SYNC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SYNC: state_d = S_WAITDS;
            S_WAITDS: begin
                cont_d = 1'b0;
                if (!s_ndinc) begin
                    rd_d    = 1'b1;
                    state_d = S_WAITRP;
                end else if (!s_ndoutc) begin
                    rd_d    = 1'b0;
                    wtbt_d  = s_nwtbtc;
                    state_d = S_WDATA;
                end else if (s_nsyncc) begin
                    state_d = S_FINISH;
                end
            end
            S_WDATA: begin
                if (cnt_q == CW'(T_SETUP - 1)) begin
                    state_d = S_WAITRP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAITRP: begin
                if (!s_nrplyp) begin
                    state_d = rd_q ? S_RDLAT : S_RPLY;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RDLAT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_RPLY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RPLY: begin
                if (s_ndinc && s_ndoutc) begin
                    cont_d  = ~s_nsyncc;
                    state_d = S_FINISH;
                end
            end
            // Also the DATIO turnaround: with SYNC still low, wait out RPLYP and take the next strobe.
            S_FINISH: begin
                if (s_nrplyp) begin
                    if (s_nsyncc) begin
                        state_d = S_IDLE;
                        cont_d  = 1'b0;
                    end else if (cont_q) begin
                        state_d = S_WAITDS;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PIN_nRPLYC = 1'b1;
        PIN_nSYNCP = 1'b1;
        PIN_nDINP  = 1'b1;
        PIN_nDOUTP = 1'b1;
        PIN_nWTBTP = 1'b1;
        PIN_nDLA   = 1'b1;
        PIN_nDLD   = 1'b1;
        PIN_nCLD   = 1'b1;
        PIN_nOEP   = 1'b1;
        PIN_nOEC   = 1'b1;
        PIN_BUSY   = (state_q != S_IDLE);
        PIN_TOUT   = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_ADDR: begin
                PIN_nOEP = 1'b0;
                PIN_nDLA = (cnt_q != '0);
            end
            S_SYNC: begin
                PIN_nSYNCP = 1'b0;
                PIN_nOEP   = 1'b0;
            end
            S_WAITDS: PIN_nSYNCP = 1'b0;
            S_WDATA: begin
                PIN_nSYNCP = 1'b0;
                PIN_nOEP   = 1'b0;
                PIN_nDLD   = (cnt_q != '0);
            end
            S_WAITRP: begin
                PIN_nSYNCP = 1'b0;
                PIN_TOUT   = s_nrplyp && (cnt_q == CW'(TIMEOUT - 1));
                if (rd_q) begin
                    PIN_nDINP = 1'b0;
                end else begin
                    PIN_nDOUTP = 1'b0;
                    PIN_nWTBTP = wtbt_q;
                    PIN_nOEP   = 1'b0;
                end
            end
            S_RDLAT: begin
                PIN_nSYNCP = 1'b0;
                PIN_nDINP  = 1'b0;
                PIN_nCLD   = (cnt_q != '0);
                PIN_nOEC   = (cnt_q == '0);
            end
            S_RPLY: begin
                PIN_nSYNCP = 1'b0;
                PIN_nRPLYC = 1'b0;
                if (rd_q) begin
                    PIN_nDINP = 1'b0;
                    PIN_nOEC  = 1'b0;
                end else begin
                    PIN_nDOUTP = 1'b0;
                    PIN_nWTBTP = wtbt_q;
                    PIN_nOEP   = 1'b0;
                end
            end
            S_FINISH: PIN_nSYNCP = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vp_095_seq.sv
// tb_vp_095_seq: directed cycle-by-cycle bench for the vp_095 bus sequencer.
// Each input change reaches the state machine three rising edges later (two sync flops plus the state register).
module tb_vp_095_seq;

    localparam logic [11:0] RPLYC = 12'h800, SYNCP = 12'h400, DINP = 12'h200, DOUTP = 12'h100;
    localparam logic [11:0] WTBTP = 12'h080, DLA = 12'h040, DLD = 12'h020, CLD = 12'h010;
    localparam logic [11:0] OEP = 12'h008, OEC = 12'h004, BSY = 12'h002, TO = 12'h001;
    localparam logic [11:0] IDLE_V = 12'hFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, nsyncc, ndinc, ndoutc, nwtbtc, nrplyp;
    logic [1:0] ncmpc;
    logic       nrplyc, nsyncp, ndinp, ndoutp, nwtbtp, ndla, ndld, ncld, noep, noec, busy, tout;
    logic [11:0] obs;
    logic [11:0] obs_prev = 12'hFFC;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned dla_falls = 0, syncp_falls = 0, rplyc_falls = 0;

    vp_095_seq #(.T_SETUP(2), .TIMEOUT(16), .CW(8)) dut (
        .PIN_CLK(clk), .PIN_nRST(rst_n), .PIN_nSYNCC(nsyncc), .PIN_nDINC(ndinc),
        .PIN_nDOUTC(ndoutc), .PIN_nWTBTC(nwtbtc), .PIN_nCMPC(ncmpc), .PIN_nRPLYP(nrplyp),
        .PIN_nRPLYC(nrplyc), .PIN_nSYNCP(nsyncp), .PIN_nDINP(ndinp), .PIN_nDOUTP(ndoutp),
        .PIN_nWTBTP(nwtbtp), .PIN_nDLA(ndla), .PIN_nDLD(ndld), .PIN_nCLD(ncld),
        .PIN_nOEP(noep), .PIN_nOEC(noec), .PIN_BUSY(busy), .PIN_TOUT(tout)
    );

    assign obs = {nrplyc, nsyncp, ndinp, ndoutp, nwtbtp, ndla, ndld, ncld, noep, noec, busy, tout};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mask lists the asserted signals; active-low bits invert against the idle pattern
    task automatic run(input string tag, input logic [11:0] mask, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            chk(tag, {20'd0, obs}, {20'd0, mask ^ IDLE_V});
            step();
        end
    endtask

    always @(negedge clk) begin
        if (obs_prev[6] && !obs[6]) dla_falls <= dla_falls + 1;
        if (obs_prev[10] && !obs[10]) syncp_falls <= syncp_falls + 1;
        if (obs_prev[11] && !obs[11]) rplyc_falls <= rplyc_falls + 1;
        obs_prev <= obs;
        if (rst_n) begin
            chk("inv_din_dout", {31'd0, ~ndinp & ~ndoutp}, 32'd0);
            chk("inv_oep_oec", {31'd0, ~noep & ~noec}, 32'd0);
        end
    end

    task automatic do_addr();
        nsyncc = 1'b0;
        ncmpc  = 2'b00;
        run("sync_lat", '0, 3);
        run("addr_dla", DLA | OEP | BSY, 1);
        run("addr_setup", OEP | BSY, 2);
        run("sync_hold", SYNCP | OEP | BSY, 1);
    endtask

    task automatic do_dato();
        do_addr();
        ndoutc = 1'b0;
        nwtbtc = 1'b1;
        run("waitds_w", SYNCP | BSY, 3);
        run("wdata_dld", SYNCP | DLD | OEP | BSY, 1);
        run("wdata_setup", SYNCP | OEP | BSY, 1);
        run("waitrp_w", SYNCP | DOUTP | OEP | BSY, 5);
        nrplyp = 1'b0;
        run("waitrp_w_sync", SYNCP | DOUTP | OEP | BSY, 3);
        run("rply_w", RPLYC | SYNCP | DOUTP | OEP | BSY, 2);
        ndoutc = 1'b1;
        run("rply_w_hold", RPLYC | SYNCP | DOUTP | OEP | BSY, 3);
        nrplyp = 1'b1;
        nsyncc = 1'b1;
        ncmpc  = 2'b11;
        run("finish_w", SYNCP | BSY, 3);
        run("idle_w", '0, 2);
    endtask

    task automatic read_phase();
        ndinc = 1'b0;
        run("waitds_r", SYNCP | BSY, 3);
        run("waitrp_r", SYNCP | DINP | BSY, 2);
        nrplyp = 1'b0;
        run("waitrp_r_sync", SYNCP | DINP | BSY, 3);
        run("rdlat_cld", SYNCP | DINP | CLD | BSY, 1);
        run("rdlat_oec", SYNCP | DINP | OEC | BSY, 1);
        run("rply_r", RPLYC | SYNCP | DINP | OEC | BSY, 1);
        ndinc = 1'b1;
        run("rply_r_hold", RPLYC | SYNCP | DINP | OEC | BSY, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, s0, r0;
        rst_n = 1'b0; nsyncc = 1'b1; ndinc = 1'b1; ndoutc = 1'b1;
        nwtbtc = 1'b1; nrplyp = 1'b1; ncmpc = 2'b11;
        #1;
        chk("reset_outs", {20'd0, obs}, {20'd0, IDLE_V});
        step(); step();
        rst_n = 1'b1;
        run("idle_start", '0, 3);

        do_dato();

        do_addr();
        read_phase();
        nrplyp = 1'b1;
        nsyncc = 1'b1;
        ncmpc  = 2'b11;
        run("finish_r", SYNCP | BSY, 3);
        run("idle_r", '0, 2);

        d0 = dla_falls; s0 = syncp_falls; r0 = rplyc_falls;
        do_addr();
        read_phase();
        nrplyp = 1'b1;
        run("datio_turn", SYNCP | BSY, 3);
        ndoutc = 1'b0;
        nwtbtc = 1'b0;
        run("datio_waitds", SYNCP | BSY, 3);
        run("datio_dld", SYNCP | DLD | OEP | BSY, 1);
        run("datio_setup", SYNCP | OEP | BSY, 1);
        run("datio_waitrp", SYNCP | DOUTP | WTBTP | OEP | BSY, 1);
        nrplyp = 1'b0;
        run("datio_waitrp_sync", SYNCP | DOUTP | WTBTP | OEP | BSY, 3);
        run("datio_rply", RPLYC | SYNCP | DOUTP | WTBTP | OEP | BSY, 1);
        ndoutc = 1'b1;
        nwtbtc = 1'b1;
        run("datio_rply_hold", RPLYC | SYNCP | DOUTP | WTBTP | OEP | BSY, 3);
        nrplyp = 1'b1;
        nsyncc = 1'b1;
        ncmpc  = 2'b11;
        run("datio_finish", SYNCP | BSY, 3);
        run("datio_idle", '0, 2);
        chk("datio_dla_falls", dla_falls - d0, 32'd1);
        chk("datio_syncp_falls", syncp_falls - s0, 32'd1);
        chk("datio_rplyc_falls", rplyc_falls - r0, 32'd2);

        do_addr();
        ndoutc = 1'b0;
        run("to_waitds", SYNCP | BSY, 3);
        run("to_dld", SYNCP | DLD | OEP | BSY, 1);
        run("to_setup", SYNCP | OEP | BSY, 1);
        run("to_waitrp", SYNCP | DOUTP | OEP | BSY, 15);
        run("to_pulse", SYNCP | DOUTP | OEP | BSY | TO, 1);
        run("to_finish", SYNCP | BSY, 3);
        ndoutc = 1'b1;
        nsyncc = 1'b1;
        ncmpc  = 2'b11;
        run("to_finish_rel", SYNCP | BSY, 3);
        run("to_idle", '0, 2);

        nsyncc = 1'b0;
        ncmpc  = 2'b01;
        run("miss_sync", '0, 4);
        ndinc = 1'b0;
        run("miss_din", '0, 5);
        ndinc  = 1'b1;
        nsyncc = 1'b1;
        ncmpc  = 2'b11;
        run("miss_release", '0, 4);
        do_dato();

        do_addr();
        ndoutc = 1'b0;
        run("rst_waitds", SYNCP | BSY, 3);
        run("rst_dld", SYNCP | DLD | OEP | BSY, 1);
        run("rst_setup", SYNCP | OEP | BSY, 1);
        run("rst_waitrp", SYNCP | DOUTP | OEP | BSY, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_immediate", {20'd0, obs}, {20'd0, IDLE_V});
        ndoutc = 1'b1;
        nsyncc = 1'b1;
        ncmpc  = 2'b11;
        step(); step();
        chk("rst_held", {20'd0, obs}, {20'd0, IDLE_V});
        rst_n = 1'b1;
        run("rst_idle", '0, 3);
        do_dato();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
